// File: rtl/brcomp_seq.sv
// Multi-cycle branch comparator. Operands are scanned CHUNK bits per cycle from
// the MSB down, and the RISC-V branch funct3 is decoded into a taken flag.
module brcomp_seq #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    input  logic [2:0]       br_op_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             br_less_o,
    output logic             br_equal_o,
    output logic             br_taken_o
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             found_q, less_first_q;

    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic             chunk_diff, chunk_lt, last_step;
    logic             fin_equal, fin_less;

    function automatic logic decode_taken(input logic [2:0] op, input logic eq, input logic lt);
        case (op)
            3'b000:         return eq;
            3'b001:         return ~eq;
            3'b100, 3'b110: return lt;
            3'b101, 3'b111: return ~lt;
            default:        return 1'b0;
        endcase
    endfunction

    // Operands shift left each step, so the chunk under test is always the top one.
    // Flipping the sign bit on the first chunk turns signed order into unsigned order.
    always_comb begin
        chunk_a = a_q[WIDTH-1 -: CHUNK];
        chunk_b = b_q[WIDTH-1 -: CHUNK];
        if (cnt_q == '0 && !op_q[1]) begin
            chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
            chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
        end
        chunk_diff = (chunk_a != chunk_b);
        chunk_lt   = (chunk_a < chunk_b);
        last_step  = (cnt_q == LAST_STEP) || ((EARLY_EXIT != 0) && chunk_diff);
        fin_equal  = !found_q && !chunk_diff;
        fin_less   = found_q ? less_first_q : (chunk_diff && chunk_lt);
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)   state_d = SCAN;
            SCAN:    if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign busy_o = (state_q == SCAN);

    // NOTE: operand/op latches carry no reset; they are always loaded before use,
    // and only control and visible result state is cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            found_q      <= 1'b0;
            less_first_q <= 1'b0;
            done_o       <= 1'b0;
            br_less_o    <= 1'b0;
            br_equal_o   <= 1'b0;
            br_taken_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state_q == IDLE) begin
                if (start_i) begin
                    a_q     <= rs1_data_i;
                    b_q     <= rs2_data_i;
                    op_q    <= br_op_i;
                    cnt_q   <= '0;
                    found_q <= 1'b0;
                end
            end else begin
                a_q   <= WIDTH'(a_q << CHUNK);
                b_q   <= WIDTH'(b_q << CHUNK);
                cnt_q <= cnt_q + 1'b1;
                if (!found_q && chunk_diff) begin
                    found_q      <= 1'b1;
                    less_first_q <= chunk_lt;
                end
                if (last_step) begin
                    br_less_o  <= fin_less;
                    br_equal_o <= fin_equal;
                    br_taken_o <= decode_taken(op_q, fin_equal, fin_less);
                    done_o     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_brcomp_seq.sv
// Directed bench for brcomp_seq: one early-exit instance and one constant-time
// instance sharing operand inputs, with hand-computed expected results.
module tb_brcomp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_e, start_c;
    logic [31:0] rs1, rs2;
    logic [2:0]  op;

    logic busy_e, done_e, less_e, eq_e, taken_e;
    logic busy_c, done_c, less_c, eq_c, taken_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    brcomp_seq #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_e),
        .rs1_data_i(rs1), .rs2_data_i(rs2), .br_op_i(op),
        .busy_o(busy_e), .done_o(done_e), .br_less_o(less_e),
        .br_equal_o(eq_e), .br_taken_o(taken_e)
    );

    brcomp_seq #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(0)) dut_ct (
        .clk_i(clk), .rst_i(rst), .start_i(start_c),
        .rs1_data_i(rs1), .rs2_data_i(rs2), .br_op_i(op),
        .busy_o(busy_c), .done_o(done_c), .br_less_o(less_c),
        .br_equal_o(eq_c), .br_taken_o(taken_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one operation on the chosen instance and check latency and results.
    // Done is expected k+1 negedges after the start negedge (k = steps taken).
    task automatic run_op(input string tag, input bit ct, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input int k,
                          input bit x_less, input bit x_eq, input bit x_taken);
        int n;
        logic dn;
        rs1 = a; rs2 = b; op = f3;
        if (ct) start_c = 1'b1; else start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0; start_c = 1'b0;
        rs1 = ~a; rs2 = a ^ b; op = 3'b010;
        n = 1;
        check({tag, ".busy"}, ct ? busy_c : busy_e, 1);
        dn = ct ? done_c : done_e;
        while (!dn && n < 40) begin
            @(negedge clk);
            n++;
            dn = ct ? done_c : done_e;
        end
        check({tag, ".lat"}, n, k + 1);
        check({tag, ".busy_done"}, ct ? busy_c : busy_e, 0);
        check({tag, ".less"}, ct ? less_c : less_e, x_less);
        check({tag, ".eq"}, ct ? eq_c : eq_e, x_eq);
        check({tag, ".taken"}, ct ? taken_c : taken_e, x_taken);
        @(negedge clk);
        check({tag, ".pulse"}, ct ? done_c : done_e, 0);
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1; start_e = 1'b0; start_c = 1'b0;
        rs1 = '0; rs2 = '0; op = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst.busy", busy_e, 0);
        check("rst.done", done_e, 0);
        check("rst.res", {less_e, eq_e, taken_e}, 0);
        check("rst.res_ct", {busy_c, done_c, less_c, eq_c, taken_c}, 0);

        run_op("blt_neg",   0, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 0, 1);
        run_op("bltu_big",  0, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 0, 0);
        run_op("beq_eq",    0, 3'b000, 32'h1234_5678, 32'h1234_5678, 8, 0, 1, 1);
        run_op("bne_eq",    0, 3'b001, 32'h1234_5678, 32'h1234_5678, 8, 0, 1, 0);
        run_op("bge_lsb",   0, 3'b101, 32'h0000_0010, 32'h0000_0011, 8, 1, 0, 0);
        run_op("bgeu_msb",  0, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 0, 1);
        run_op("blt_minmax",0, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1, 1, 0, 1);
        run_op("inv010",    0, 3'b010, 32'h0000_0005, 32'h0000_0003, 8, 0, 0, 0);
        run_op("inv011",    0, 3'b011, 32'h0000_0003, 32'h0000_0005, 8, 1, 0, 0);
        run_op("ct_blt",    1, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 8, 1, 0, 1);
        run_op("ct_first",  1, 3'b100, 32'h0100_000F, 32'h0200_0000, 8, 1, 0, 1);

        // Second start mid-scan is ignored; results hold while busy.
        rs1 = 32'h1234_5678; rs2 = 32'h1234_5678; op = 3'b000; start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rs1 = '0; rs2 = '0; op = 3'b001; start_e = 1'b1;
        check("hs.hold_less", less_e, 1);
        @(negedge clk);
        start_e = 1'b0;
        n = 4; seen = 0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            seen = done_e;
        end
        check("hs.lat", n, 9);
        check("hs.eq", eq_e, 1);
        check("hs.taken", taken_e, 1);
        // Start in the done cycle is accepted.
        rs1 = 32'hFFFF_FFFF; rs2 = 32'h1; op = 3'b110; start_e = 1'b1;
        @(negedge clk);
        check("hs.accept_busy", busy_e, 1);
        // Start held across the termination edge must be ignored.
        rs1 = 32'h0; rs2 = 32'h0;
        op = 3'b000;
        @(negedge clk);
        check("hs.done2", done_e, 1);
        check("hs.taken2", taken_e, 0);
        start_e = 1'b0;
        @(negedge clk);
        check("hs.term_ignored", busy_e, 0);

        // Reset in scan step 3 aborts with no done.
        run_op("pre_rst", 0, 3'b000, 32'hA, 32'hA, 8, 0, 1, 1);
        rs1 = 32'h5; rs2 = 32'h5; op = 3'b000; start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        @(negedge clk);
        check("rs.hold_eq", eq_e, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs.state", {busy_e, done_e, less_e, eq_e, taken_e}, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_e || busy_e) seen = 1;
        end
        check("rs.no_done", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
